// File: rtl/half_image_loader_pkg.sv
// rtl/half_image_loader_pkg.sv - shared half-precision types, loader state and byte-to-half table builder
package half_image_loader_pkg;

  typedef logic [15:0] half_t;

  localparam int NPIX_MNIST = 784;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_FIRE,
    ST_BUSY
  } loader_state_t;

  // p/255 is never a rounding tie (odd divisor), so RNE reduces to "round up when remainder > half".
  function automatic half_t u8_to_half(input int p);
    half_t h;
    int k;
    int num;
    int q;
    int r;
    h = '0;
    k = 0;
    if (p != 0) begin
      for (int i = 0; i < 8; i++) begin
        if ((p << k) < 255) k = k + 1;
      end
      num = p << (10 + k);
      q   = num / 255;
      r   = num % 255;
      if (2 * r > 255) q = q + 1;
      if (q == 2048) begin
        q = 1024;
        k = k - 1;
      end
      h = {1'b0, 5'(15 - k), 10'(q)};
    end
    return h;
  endfunction

  function automatic logic [256*16-1:0] build_half_lut();
    logic [256*16-1:0] lut;
    lut = '0;
    for (int i = 0; i < 256; i++) begin
      lut[i*16 +: 16] = u8_to_half(i);
    end
    return lut;
  endfunction

endpackage

// File: rtl/half_image_loader_if.sv
// rtl/half_image_loader_if.sv - byte-serial pixel stream with valid/ready handshake
interface half_image_loader_if;
  logic       pix_valid;
  logic       pix_first;
  logic [7:0] pix_data;
  logic       pix_ready;

  modport master (
    output pix_valid,
    output pix_first,
    output pix_data,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_first,
    input  pix_data,
    output pix_ready
  );
endinterface

// File: rtl/half_u8_norm.sv
// rtl/half_u8_norm.sv - combinational ROM mapping a pixel byte p to binary16 p/255
module half_u8_norm
  import half_image_loader_pkg::*;
(
  input  logic [7:0] pix_data,
  output half_t      half
);

  localparam logic [256*16-1:0] LUT = build_half_lut();

  assign half = LUT[{pix_data, 4'b0000} +: 16];

endmodule

// File: rtl/half_image_loader.sv
// rtl/half_image_loader.sv - assembles a pixel stream into the half vector x and launches layer 1
module half_image_loader
  import half_image_loader_pkg::*;
#(
  parameter int NPIX  = NPIX_MNIST,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  half_image_loader_if.slave   pix,
  input  logic                 done,
  output half_t                x [NPIX],
  output logic                 start,
  output logic [CNT_W-1:0]     image_count,
  output logic                 frame_err
);

  localparam int              IDX_W = $clog2(NPIX);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NPIX - 1);

  loader_state_t    state;
  logic [IDX_W-1:0] idx;
  logic             ready;
  logic             xfer;
  half_t            half;

  half_u8_norm u_norm (
    .pix_data (pix.pix_data),
    .half     (half)
  );

  assign xfer          = pix.pix_valid & ready;
  assign pix.pix_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FILL;
      idx         <= '0;
      ready       <= 1'b0;
      start       <= 1'b0;
      image_count <= '0;
      frame_err   <= 1'b0;
      for (int i = 0; i < NPIX; i++) x[i] <= '0;
    end else begin
      start <= 1'b0;
      unique case (state)
        ST_FILL: begin
          ready <= 1'b1;
          if (xfer) begin
            // A frame marker mid-image restarts the frame with this byte as pixel 0.
            if (pix.pix_first && (idx != '0)) begin
              x[0]      <= half;
              idx       <= IDX_W'(1);
              frame_err <= 1'b1;
            end else begin
              x[idx] <= half;
              if (idx == LAST) begin
                idx         <= '0;
                ready       <= 1'b0;
                start       <= 1'b1;
                image_count <= image_count + 1'b1;
                state       <= ST_FIRE;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        ST_FIRE: begin
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (done) begin
            state <= ST_FILL;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule
